// File: rtl/aes_io_pkg.sv
// Shared types and sizing for the AES I/O controller.
// The zeroize option is selected with the AES_IO_ZEROIZE_EN macro in aes_io_ctrl.
package aes_io_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLK_W           = 128;
    localparam int unsigned WORDS           = 4;
    localparam int unsigned AES_LATENCY_DEF = 21;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCapture,
        StDrain
    } state_e;

endpackage

// File: rtl/aes_io_ser.sv
// Ciphertext buffer and word serializer: loads a 128-bit block and streams it
// out as four 32-bit words, most-significant word first, under valid/ready.
module aes_io_ser
    import aes_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [BLK_W-1:0]  din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int unsigned PTR_W = $clog2(WORDS);

    logic [BLK_W-1:0] obuf_q;
    logic [PTR_W-1:0] ptr_q;
    int unsigned      rd_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            obuf_q <= '0;
            ptr_q  <= '0;
        end else if (load) begin
            obuf_q <= din;
            ptr_q  <= '0;
        end else if (drain && out_ready) begin
            ptr_q <= done ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        rd_base   = (WORDS - 1 - 32'(ptr_q)) * WORD_W;
        out_valid = drain;
        out_data  = drain ? obuf_q[rd_base +: WORD_W] : '0;
        out_last  = drain && (32'(ptr_q) == WORDS - 1);
        done      = out_last && out_ready;
    end

endmodule

// File: rtl/aes_io_ctrl.sv
// Word-wide front end for an external aes_128 core: loads state/key, waits the
// core latency, then serializes the ciphertext. Define AES_IO_ZEROIZE_EN to clear the key on capture.
module aes_io_ctrl
    import aes_io_pkg::*;
#(
    parameter int unsigned AES_LATENCY = AES_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [1:0]        in_idx,
    input  logic [WORD_W-1:0] in_data,
    input  logic              start,
    output logic              busy,
    output logic [BLK_W-1:0]  aes_state,
    output logic [BLK_W-1:0]  aes_key,
    input  logic [BLK_W-1:0]  aes_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned CNT_W = $clog2(AES_LATENCY + 1);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] state_q, key_q;
    logic             wr_en, capture, drain, done;
    int unsigned      wr_base;

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        capture  = 1'b0;
        drain    = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b1;
        wr_base  = (WORDS - 1 - 32'(in_idx)) * WORD_W;
        unique case (st_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                wr_en    = in_valid;
                // A same-cycle write lands on the same edge as the launch.
                if (start) begin
                    st_d  = StWait;
                    cnt_d = CNT_W'(AES_LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    st_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                st_d    = StDrain;
            end
            StDrain: begin
                drain = 1'b1;
                if (done) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            cnt_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                if (in_sel) begin
                    key_q[wr_base +: WORD_W] <= in_data;
                end else begin
                    state_q[wr_base +: WORD_W] <= in_data;
                end
            end
`ifdef AES_IO_ZEROIZE_EN
            if (capture) begin
                key_q <= '0;
            end
`endif
        end
    end

    assign aes_state = state_q;
    assign aes_key   = key_q;

    aes_io_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .drain     (drain),
        .din       (aes_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

endmodule

// File: doc/aes_io_ctrl.md
AES_IO_CTRL -- requirements
Module: aes_io_ctrl

Interface
REQ-001 SHALL have parameter AES_LATENCY, default 21: cycles from aes_state/aes_key change to valid aes_out.
REQ-002 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: word-write request.
REQ-005 SHALL have port in_ready, output, 1: word write accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_sel, input, 1: 0 selects the state register, 1 selects the key register.
REQ-007 SHALL have port in_idx, input, 2: word index; 0 addresses bits [127:96] and 3 addresses bits [31:0].
REQ-008 SHALL have port in_data, input, 32: write word.
REQ-009 SHALL have port start, input, 1: launch-encryption pulse.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port aes_state, output, 128: plaintext driven to the aes_128 state input.
REQ-012 SHALL have port aes_key, output, 128: key driven to the aes_128 key input.
REQ-013 SHALL have port aes_out, input, 128: ciphertext from aes_128 out.
REQ-014 SHALL have port out_valid, output, 1: ciphertext word available.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the word.
REQ-016 SHALL have port out_data, output, 32: ciphertext word, most-significant word first.
REQ-017 SHALL have port out_last, output, 1: high with the fourth (final) word.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, CAPTURE and DRAIN.
REQ-019 IDLE: in_ready=1; each accepted word writes the 32-bit slice selected by in_sel/in_idx; all other bits hold.
REQ-020 IDLE with start=1: SHALL go to WAIT and load the latency counter with AES_LATENCY-1.
REQ-021 in_valid and start in the same cycle: the word SHALL be written first, and the launch SHALL include it.
REQ-022 WAIT: in_ready=0; the counter decrements each cycle; at 0 the FSM SHALL go to CAPTURE.
REQ-023 CAPTURE: SHALL latch aes_out into the 128-bit output buffer in one cycle, then go to DRAIN with word pointer 0.
REQ-024 DRAIN: out_valid=1 and out_data=buffer word[ptr]; on out_valid and out_ready, ptr SHALL increment.
REQ-025 DRAIN: after the handshake on ptr=3 (out_last=1), the FSM SHALL return to IDLE.
REQ-026 DRAIN with out_ready low: out_data and out_last SHALL hold stable; stalls of any length are allowed.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside IDLE is not accepted and causes no write.
REQ-028 aes_state and aes_key SHALL be driven directly from their registers and stay constant from launch through CAPTURE.
REQ-029 AES_LATENCY SHALL be at least 1; the counter width is $clog2(AES_LATENCY+1).

Reset
REQ-030 rst=1 SHALL, at the next clock edge, force IDLE and clear the state, key and output buffers, the counter and ptr to 0.
REQ-031 After reset, outputs SHALL be busy=0, in_ready=1, out_valid=0, out_last=0, out_data=0, aes_state=0 and aes_key=0.
REQ-032 rst asserted in WAIT or DRAIN SHALL abort the operation, and no further out_valid SHALL occur for it.

Configuration
REQ-033 With macro AES_IO_ZEROIZE_EN defined, the key register SHALL clear to 0 in the CAPTURE cycle, so every launch needs a fresh key load.
REQ-034 Without AES_IO_ZEROIZE_EN, the key SHALL be retained across operations; only rst or new writes change it.

Structure
REQ-035 Package aes_io_pkg SHALL hold the FSM state enum, WORD_W=32, BLK_W=128, WORDS=4 and the default AES_LATENCY.
REQ-036 The output buffer with its word pointer and out handshake SHALL be the sub-module aes_io_ser; all else is flat.

Verification
REQ-037 Scenario 1: load key 000102030405060708090a0b0c0d0e0f and state 00112233445566778899aabbccddeeff, pulse start, with aes_128 attached -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, and out_last on the fourth.
REQ-038 Scenario 2: hold out_ready low for 5 cycles in DRAIN -> out_data stays 69c4e0d8 and out_valid stays 1.
REQ-039 Scenario 3: start in the same cycle as a write of state word idx3=ccddeeff -> the launched aes_state[31:0]=ccddeeff.
REQ-040 Scenario 4: rst at WAIT count 10 -> next cycle busy=0 and aes_key=0, and out_valid never rises.
REQ-041 Scenario 5: with AES_IO_ZEROIZE_EN defined, after one operation -> aes_key=0; without it -> the key is unchanged.
REQ-042 Scenario 6: start pulsed in WAIT or DRAIN and in_valid in WAIT -> no relaunch, no register write, and exactly 4 output words.
